// File: rtl/conv_feeder.sv
// Conv feeder: splits one beat stream into kernel/bias loads and packed pixel words.
// Kernels are staged in shadow registers and presented atomically with a buff_en pulse.
module conv_feeder_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= d;
  end
endmodule

module conv_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_UNITS = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_user,
  input  logic                            s_last,
  output logic [DATA_WIDTH*TOTAL_UNITS-1:0] x_in,
  output logic                            dv_in,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           K1,
  output logic [DATA_WIDTH-1:0]           K2,
  output logic [DATA_WIDTH-1:0]           K3,
  output logic [DATA_WIDTH-1:0]           K4,
  output logic [DATA_WIDTH-1:0]           K5,
  output logic [DATA_WIDTH-1:0]           K6,
  output logic [DATA_WIDTH-1:0]           K7,
  output logic [DATA_WIDTH-1:0]           K8,
  output logic [DATA_WIDTH-1:0]           K9,
  output logic [DATA_WIDTH*3-1:0]         bias,
  output logic                            buff_en,
  output logic                            err
);
  localparam int LW = (TOTAL_UNITS > 1) ? $clog2(TOTAL_UNITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_K, PIX} state_t;

  state_t                                 state;
  logic                                   run;
  logic [3:0]                             kcnt;
  logic [LW-1:0]                          lcnt;
  logic [8:0][DATA_WIDTH-1:0]             ksh, kreg;
  logic [2:0][DATA_WIDTH-1:0]             bsh, breg;
  logic [TOTAL_UNITS-1:0][DATA_WIDTH-1:0] pack, word;
  logic [TOTAL_UNITS-1:0]                 lane_wr;
  logic                                   acc, pix_acc, pix_done;

  // run keeps s_ready low while reset is held, even though dv_in is 0 then
  assign s_ready  = run && !(dv_in && !m_ready);
  assign acc      = s_valid && s_ready;
  assign pix_acc  = acc && !s_user && (state != LOAD_K);
  assign pix_done = pix_acc && (s_last || (lcnt == LW'(TOTAL_UNITS-1)));

  genvar i;
  generate
    for (i = 0; i < TOTAL_UNITS; i++) begin : g_lane
      assign lane_wr[i] = pix_acc && (lcnt == LW'(i));
      // completing beat bypasses the lane register straight into the output word
      assign word[i]    = lane_wr[i] ? s_data : pack[i];
      conv_feeder_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk (clk),
        .rstn(rstn),
        .wr  (lane_wr[i]),
        .clr (pix_done),
        .d   (s_data),
        .q   (pack[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      run     <= 1'b0;
      kcnt    <= '0;
      lcnt    <= '0;
      ksh     <= '0;
      bsh     <= '0;
      kreg    <= '0;
      breg    <= '0;
      x_in    <= '0;
      dv_in   <= 1'b0;
      buff_en <= 1'b0;
      err     <= 1'b0;
    end else begin
      run     <= 1'b1;
      buff_en <= 1'b0;
      if (pix_done) begin
        x_in  <= word;
        dv_in <= 1'b1;
      end else if (dv_in && m_ready) begin
        dv_in <= 1'b0;
      end
      if (pix_acc) lcnt <= pix_done ? '0 : lcnt + 1'b1;
      case (state)
        IDLE: if (acc) begin
          if (s_user) begin
            ksh[0] <= s_data;
            kcnt   <= 4'd1;
            state  <= LOAD_K;
          end else begin
            state  <= s_last ? IDLE : PIX;
          end
        end
        LOAD_K: if (acc) begin
          if (!s_user || s_last) begin
            err   <= 1'b1;
            kcnt  <= '0;
            state <= IDLE;
          end else begin
            if (kcnt < 4'd9) ksh[kcnt] <= s_data;
            else             bsh[kcnt[1:0] - 2'd1] <= s_data;
            kcnt <= kcnt + 4'd1;
            if (kcnt == 4'd11) begin
              kreg    <= ksh;
              breg    <= {s_data, bsh[1], bsh[0]};
              buff_en <= 1'b1;
              kcnt    <= '0;
              state   <= IDLE;
            end
          end
        end
        PIX: if (acc) begin
          if (s_user)      err   <= 1'b1;
          else if (s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign K1   = kreg[0];
  assign K2   = kreg[1];
  assign K3   = kreg[2];
  assign K4   = kreg[3];
  assign K5   = kreg[4];
  assign K6   = kreg[5];
  assign K7   = kreg[6];
  assign K8   = kreg[7];
  assign K9   = kreg[8];
  assign bias = breg;
endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, sample width; TOTAL_UNITS, 8, lanes per packed output word.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  reset, asynchronous and active-low; the block SHALL use one clock with this reset.
REQ-004 s_data  input  DATA_WIDTH  stream beat (kernel, bias or pixel).
REQ-005 s_valid  input  1  beat valid; s_ready  output  1  beat accepted when s_valid && s_ready.
REQ-006 s_user  input  1  1 = kernel/bias beat, 0 = pixel beat.
REQ-007 s_last  input  1  last pixel beat of a row.
REQ-008 x_in  output  DATA_WIDTH*TOTAL_UNITS  packed pixel word; lane i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-009 dv_in  output  1  x_in valid; m_ready  input  1  downstream accepts when dv_in && m_ready.
REQ-010 K1..K9  output  DATA_WIDTH each  kernel coefficients; bias  output  DATA_WIDTH*3  bias triple.
REQ-011 buff_en  output  1  one-cycle pulse when a new K1..K9/bias set is presented.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD_K and PIX.
REQ-014 s_ready SHALL be !(dv_in && !m_ready) in every state; it SHALL be 0 in reset.
REQ-015 IDLE, accepted beat with s_user=1: store as shadow K1, kcnt=1, go to LOAD_K.
REQ-016 IDLE, accepted beat with s_user=0: store in lane 0, lcnt=1, go to PIX; the current kernels are retained.
REQ-017 LOAD_K: accepted beat kcnt=0..8 SHALL go to shadow K(kcnt+1); kcnt=9,10,11 SHALL go to bias[DW-1:0], [2DW-1:DW], [3DW-1:2DW] respectively.
REQ-018 On acceptance of beat kcnt=11, K1..K9/bias outputs SHALL load from the shadow registers at the next edge, buff_en SHALL be 1 for exactly that one cycle, and the FSM SHALL go to IDLE.
REQ-019 LOAD_K accepted beat with s_user=0 or s_last=1 SHALL set err, drop the beat, leave K1..K9/bias outputs unchanged, and go to IDLE.
REQ-020 PIX: an accepted beat SHALL write lane lcnt, then lcnt increments.
REQ-021 When lane TOTAL_UNITS-1 is written, or on s_last, the packed word SHALL be copied to x_in at that edge with unwritten lanes zero, dv_in set, the pack buffer cleared and lcnt=0.
REQ-022 On s_last the FSM SHALL go to IDLE; otherwise it stays in PIX.
REQ-023 PIX accepted beat with s_user=1 SHALL set err and be dropped; the FSM stays in PIX.
REQ-024 dv_in SHALL hold, with x_in stable, until m_ready; on a transfer with no new word completing, dv_in SHALL clear next cycle.
REQ-025 Transfer and word completion in the same cycle SHALL load the new word with dv_in remaining 1 (full throughput, one word per TOTAL_UNITS beats).
REQ-026 Latency SHALL be one cycle from acceptance of the completing beat to dv_in=1.
REQ-027 err SHALL stay 1 until reset.

Reset
REQ-028 While rstn=0, every output (x_in, dv_in, K1..K9, bias, buff_en, err, s_ready) SHALL be 0, the FSM SHALL be IDLE, and kcnt, lcnt and the shadow/pack registers SHALL be 0.
REQ-029 Reset asserted mid-LOAD_K or mid-PIX SHALL discard partial kernels and words; after release the block SHALL start from IDLE with K1..K9=0.

Verification
V1 12 user beats 1..12, m_ready=1 -> one cycle after beat 12: buff_en=1 for 1 cycle, K1=1 .. K9=9, bias=={12,11,10}.
V2 16 pixel beats 0x0001..0x0010, last on 16th, m_ready=1 -> two dv_in words, lanes 1..8 then 9..16, each one cycle after its 8th beat.
V3 3 pixel beats 0xA,0xB,0xC with s_last on the 3rd -> x_in lanes0..2=A,B,C, lanes3..7=0, dv_in=1, FSM to IDLE.
V4 m_ready=0 while a word is pending -> s_ready=0, x_in stable, no beats lost; m_ready=1 -> transfer, s_ready=1 the same cycle.
V5 5 user beats then a pixel beat -> err=1, K outputs unchanged, no buff_en; err stays 1 until rstn=0.
V6 rstn pulsed low after 4 pixel beats -> all outputs 0; next 8 pixel beats give one word with no stale lanes.
